mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Parameters
REQ-001 The module SHALL have parameter W, default 8, giving the data width per requester.
REQ-002 The module SHALL have parameter MAX_BEATS, default 16, giving the maximum number of beats per grant before forced release; the legal range is 1..255.

Interface
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  Asynchronous, active-low reset.
REQ-005 in_valid  input  4  Per-requester valid; bit i belongs to requester i.
REQ-006 in_last  input  4  Per-requester end-of-packet marker.
REQ-007 in_data  input  4*W  Requester i data on bits [i*W +: W].
REQ-008 in_ready  output  4  Per-requester ready.
REQ-009 out_valid  output  1  Shared channel valid.
REQ-010 out_data  output  W  Shared channel data, i.e. the mux4 output.
REQ-011 out_last  output  1  Shared channel end-of-packet marker.
REQ-012 out_ready  input  1  Downstream ready.
REQ-013 sel  output  2  Current mux select {s1,s0}; equals the granted index.
REQ-014 busy  output  1  High while a grant is held.

Function
REQ-015 The module SHALL have two states: IDLE and GRANT.
REQ-016 In IDLE, if any in_valid bit is set, the module SHALL pick requester g, defined as the first index with in_valid high when scanning ptr, ptr+1, ... mod 4.
REQ-017 On that IDLE arbitration edge, the module SHALL register sel=g, enter GRANT and clear the beat counter.
REQ-018 In IDLE, the outputs SHALL be: in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0; sel holds its last value.
REQ-019 In GRANT, the datapath SHALL be combinational: out_valid=in_valid[sel], out_data=in_data[sel], out_last=in_last[sel], in_ready=one-hot(sel) AND out_ready, busy=1.
REQ-020 A beat SHALL be defined as in_valid[sel] & out_ready being high in GRANT at a rising edge; each beat SHALL increment the 8-bit beat counter.
REQ-021 The grant SHALL be released on a beat where in_last[sel]=1, or on the beat that brings the counter to MAX_BEATS, whichever comes first.
REQ-022 On release, the module SHALL set ptr=(sel+1) mod 4 (2-bit wrap, 3 goes to 0), clear the counter and return to IDLE.
REQ-023 There SHALL be exactly one idle bubble cycle between grants; the minimum request-to-first-beat latency is 1 cycle (arbitration edge, then data cycle).
REQ-024 Inputs of non-granted requesters SHALL be ignored; their in_ready SHALL be 0.
REQ-025 If in_valid[sel] drops while in GRANT, the grant SHALL be held (no timeout); out_valid SHALL follow in_valid[sel].
REQ-026 A forced release via MAX_BEATS SHALL NOT assert out_last unless in_last[sel] is high.
REQ-027 Simultaneous in_last and MAX_BEATS on the same beat SHALL cause a single release, with ptr advanced once.
REQ-028 in_valid changes in IDLE SHALL affect arbitration only at the next edge; there is no combinational path from in_valid to sel.

Reset
REQ-029 While rst_n=0, regardless of clk, the module SHALL hold: state=IDLE, sel=00, ptr=00, counter=0, busy=0, in_ready=0000, out_valid=0, out_last=0, out_data=0.
REQ-030 Reset asserted during GRANT SHALL abort the packet immediately with no beat completed; after release, arbitration SHALL resume from ptr=0.
REQ-031 Deassertion of rst_n SHALL be sampled synchronously by the design; the first arbitration SHALL occur at the first rising edge with rst_n=1.

Verification
REQ-032 Reset then in_valid=1001, in_last=1001, out_ready=1 -> grant sel=00 for 1 beat, IDLE bubble, then sel=11, then ptr=00.
REQ-033 All four requesters valid continuously with 1-beat packets -> sel sequence 00,01,10,11,00 with IDLE cycles between grants; in_ready always one-hot or zero.
REQ-034 Requester 2 sends a 3-beat packet (last on beat 3) with out_ready toggling 1,0,1,0,1 -> exactly 3 beats counted, out_data matches in_data[2W +: W] each beat, then release.
REQ-035 MAX_BEATS=4 and requester 1 streams with in_last=0 -> forced release after the 4th beat, out_last=0; if requester 1 is still the only requester, it is re-granted after the bubble.
REQ-036 rst_n pulled low mid-packet (sel=10, 2 beats done) -> outputs immediately reset per REQ-029, with no clock edge needed; after release, in_valid=0110 grants sel=01 first.
REQ-037 in_valid[sel] drops for 3 cycles mid-packet -> busy stays 1, out_valid=0, counter unchanged, no other requester granted.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of the four requester channels and the shared downstream channel
// of the 4:1 round-robin packet arbiter.
interface mux4_rr_arbiter_if #(
    parameter int W = 8
);
    logic [3:0]     in_valid;
    logic [3:0]     in_last;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic [1:0]     sel;
    logic           busy;

    modport master (
        output in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, sel, busy
    );

    modport slave (
        input  in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, sel, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// 4:1 round-robin packet arbiter: holds a grant until end-of-packet or a beat
// limit, then leaves one idle cycle before the next arbitration.
module mux4_rr_arbiter #(
    parameter int W         = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mux4_rr_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] BEAT_LIMIT = 8'(MAX_BEATS);

    state_t     state_r, state_s;
    logic [1:0] sel_r, sel_s;
    logic [1:0] ptr_r, ptr_s;
    logic [7:0] cnt_r, cnt_s;
    logic [7:0] cnt_inc_s;
    logic       beat_s;

    // First valid requester scanning ptr, ptr+1, ... with 2-bit wrap.
    function automatic logic [1:0] pick_first(input logic [3:0] valid,
                                              input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (valid[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // State, select, round-robin pointer and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            sel_r   <= 2'd0;
            ptr_r   <= 2'd0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            sel_r   <= sel_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
        end
    end

    assign cnt_inc_s = cnt_r + 8'd1;
    assign beat_s    = (state_r == GRANT) && bus.in_valid[sel_r] && bus.out_ready;
    assign bus.sel   = sel_r;

    // Next-state logic and the combinational datapath seen while granted.
    always_comb begin
        state_s       = state_r;
        sel_s         = sel_r;
        ptr_s         = ptr_r;
        cnt_s         = cnt_r;
        bus.in_ready  = 4'b0000;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = {W{1'b0}};
        bus.busy      = 1'b0;
        case (state_r)
            IDLE: begin
                if (|bus.in_valid) begin
                    sel_s   = pick_first(bus.in_valid, ptr_r);
                    state_s = GRANT;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                bus.busy      = 1'b1;
                bus.out_valid = bus.in_valid[sel_r];
                bus.out_last  = bus.in_last[sel_r];
                bus.out_data  = bus.in_data[int'(sel_r)*W +: W];
                bus.in_ready  = (4'b0001 << sel_r) & {4{bus.out_ready}};
                // A beat carrying in_last and reaching the limit releases once.
                if (beat_s && (bus.in_last[sel_r] || (cnt_inc_s == BEAT_LIMIT))) begin
                    state_s = IDLE;
                    ptr_s   = sel_r + 2'd1;
                    cnt_s   = 8'd0;
                end else if (beat_s) begin
                    cnt_s   = cnt_inc_s;
                end else begin
                    cnt_s   = cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with MAX_BEATS=4; inputs change 2 ns after
// each rising edge and outputs are checked 1 ns later, clear of any edge.
module tb_mux4_rr_arbiter;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mux4_rr_arbiter_if #(.W(W)) bus ();

    mux4_rr_arbiter #(.W(W), .MAX_BEATS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        #1;
        chk({tag, ".busy"},      32'(bus.busy),      32'd0);
        chk({tag, ".in_ready"},  32'(bus.in_ready),  32'd0);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".out_last"},  32'(bus.out_last),  32'd0);
        chk({tag, ".out_data"},  32'(bus.out_data),  32'd0);
    endtask

    task automatic chk_grant(input string tag, input logic [1:0] s,
                             input logic [3:0] rdy, input logic ov, input logic ol);
        #1;
        chk({tag, ".busy"},      32'(bus.busy),      32'd1);
        chk({tag, ".sel"},       32'(bus.sel),       32'(s));
        chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(rdy));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, ".out_last"},  32'(bus.out_last),  32'(ol));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 4'b0000;
        bus.in_last   = 4'b0000;
        bus.in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        bus.out_ready = 1'b0;

        // Reset: requests present but nothing granted while rst_n is low.
        tick();
        bus.in_valid = 4'b1111;
        tick();
        chk_idle("reset");
        chk("reset.sel", 32'(bus.sel), 32'd0);

        // 1001 with 1-beat packets: grant 0, bubble, grant 3.
        rst_n         = 1'b1;
        bus.in_valid  = 4'b1001;
        bus.in_last   = 4'b1001;
        bus.out_ready = 1'b1;
        chk_idle("no_comb_path");
        tick();
        chk_grant("g0", 2'd0, 4'b0001, 1'b1, 1'b1);
        chk("g0.data", 32'(bus.out_data), 32'h0000_00A0);
        tick();
        chk_idle("bubble0");
        chk("bubble0.sel_hold", 32'(bus.sel), 32'd0);
        tick();
        chk_grant("g3", 2'd3, 4'b1000, 1'b1, 1'b1);
        chk("g3.data", 32'(bus.out_data), 32'h0000_00D3);
        tick();
        chk_idle("bubble3");

        // All four valid, 1-beat packets: 0,1,2,3,0 starting from ptr=0.
        bus.in_valid = 4'b1111;
        bus.in_last  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_grant($sformatf("rr%0d", k), 2'(k % 4), 4'b0001 << (k % 4), 1'b1, 1'b1);
            tick();
            chk_idle($sformatf("rr%0d_bubble", k));
        end
        bus.in_valid = 4'b0000;
        bus.in_last  = 4'b0000;

        // Requester 2, 3-beat packet with out_ready stalls (ptr=1).
        bus.in_valid       = 4'b0100;
        bus.in_data[16+:8] = 8'h11;
        tick();
        chk_grant("p2b1", 2'd2, 4'b0100, 1'b1, 1'b0);
        chk("p2b1.data", 32'(bus.out_data), 32'h0000_0011);
        tick();
        bus.out_ready      = 1'b0;
        bus.in_data[16+:8] = 8'h22;
        chk_grant("p2s1", 2'd2, 4'b0000, 1'b1, 1'b0);
        chk("p2b2.data", 32'(bus.out_data), 32'h0000_0022);
        tick();
        bus.out_ready = 1'b1;
        chk_grant("p2b2", 2'd2, 4'b0100, 1'b1, 1'b0);
        tick();
        bus.out_ready      = 1'b0;
        bus.in_last        = 4'b0100;
        bus.in_data[16+:8] = 8'h33;
        chk_grant("p2s2", 2'd2, 4'b0000, 1'b1, 1'b1);
        chk("p2b3.data", 32'(bus.out_data), 32'h0000_0033);
        tick();
        bus.out_ready = 1'b1;
        chk_grant("p2b3", 2'd2, 4'b0100, 1'b1, 1'b1);
        tick();
        chk_idle("p2_release");
        bus.in_valid = 4'b0000;
        bus.in_last  = 4'b0000;

        // Requester 1 streams with no last: forced release after beat 4 (ptr=3).
        bus.in_valid = 4'b0010;
        tick();
        chk_grant("m1b1", 2'd1, 4'b0010, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk_grant("m1b4", 2'd1, 4'b0010, 1'b1, 1'b0);
        tick();
        chk_idle("m1_forced_release");
        tick();
        chk_grant("m1_regrant", 2'd1, 4'b0010, 1'b1, 1'b0);

        // Valid drop for 3 cycles after beat 1: grant held, counter frozen.
        tick();
        bus.in_valid = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            chk_grant($sformatf("drop%0d", k), 2'd1, 4'b0010, 1'b0, 1'b0);
            tick();
        end
        bus.in_valid = 4'b0010;
        chk_grant("drop_resume", 2'd1, 4'b0010, 1'b1, 1'b0);
        tick();
        tick();
        chk_grant("drop_b4", 2'd1, 4'b0010, 1'b1, 1'b0);
        tick();
        chk_idle("drop_release");

        // In_last on the limit beat: single release, ptr advances once to 2.
        tick();
        chk_grant("both_b1", 2'd1, 4'b0010, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        bus.in_last = 4'b0010;
        chk_grant("both_b4", 2'd1, 4'b0010, 1'b1, 1'b1);
        tick();
        chk_idle("both_release");
        bus.in_last  = 4'b0000;
        bus.in_valid = 4'b0111;
        tick();
        chk_grant("both_ptr", 2'd2, 4'b0100, 1'b1, 1'b0);

        // Async reset mid-packet (sel=2, 2 beats done), then resume from ptr=0.
        bus.in_valid = 4'b0100;
        tick();
        tick();
        chk_grant("rst_mid", 2'd2, 4'b0100, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        chk_idle("rst_async");
        chk("rst_async.sel", 32'(bus.sel), 32'd0);
        tick();
        bus.in_valid = 4'b0110;
        rst_n        = 1'b1;
        chk_idle("rst_release");
        tick();
        chk_grant("rst_ptr0", 2'd1, 4'b0010, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
